// File: rtl/i2s_sample_byte_packer_pkg.sv
// Shared types for the I2S sample-to-byte packer: sample/byte widths and the
// serialiser state encoding.
package i2s_pkg;

  localparam int SAMPLE_W = 24;
  localparam int BYTE_W   = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    B2   = 3'd2,
    B1   = 3'd3,
    B0   = 3'd4
  } pack_state_e;

endpackage

// File: rtl/i2s_sample_byte_packer_if.sv
// Bundles for the packer: the internal sample FIFO port and the outgoing
// byte stream. Byte stream: a byte transfers on a rising edge where valid and
// ready are both 1; while valid=1 and ready=0 the byte is held stable.
interface i2s_fifo_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] wdata;
  logic             pop;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (output push, wdata, pop, input rdata, full, empty, count);
  modport slave  (input push, wdata, pop, output rdata, full, empty, count);
endinterface

interface i2s_byte_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/i2s_sample_byte_packer_fifo.sv
// Width/depth-parameterised synchronous FIFO. Callers only assert push when
// there is room (or a pop happens on the same edge) and pop when non-empty.
module i2s_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  i2s_fifo_if.slave   f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wptr_d  = f.push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = f.pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (f.push && !f.pop) count_d = count_q + CW'(1);
    if (!f.push && f.pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (f.push) mem_q[wptr_q] <= f.wdata;
  end

  assign f.rdata = mem_q[rptr_q];
  assign f.empty = (count_q == '0);
  assign f.full  = (count_q == CW'(DEPTH));
  assign f.count = count_q;

endmodule

// File: rtl/i2s_sample_byte_packer.sv
// Buffers 24-bit capture samples and serialises each into MSB-first bytes,
// optionally preceded by a header byte, with a sticky overflow flag.
module i2s_sample_byte_packer
  import i2s_pkg::*;
#(
  parameter int              DEPTH     = 8,
  parameter logic            HEADER_EN = 1'b0,
  parameter logic [BYTE_W-1:0] HEADER  = 8'hA5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  sample_t                    data24_i,
  input  logic                       valid_i,
  output logic [BYTE_W-1:0]          byte_o,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i,
  output pack_state_e                dbg_state_o
);

  i2s_fifo_if #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) fifo_bus ();

  i2s_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .f      (fifo_bus.slave)
  );

  pack_state_e       state_q, state_d;
  sample_t           hold_q, hold_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic accept, load, pop, drop;

  // A new sample is loaded from IDLE, or straight after the last byte is
  // accepted so back-to-back samples stream without a bubble.
  assign accept = valid_q && byte_ready_i;
  assign load   = (state_q == IDLE) || (state_q == B0 && accept);
  assign pop    = load && !fifo_bus.empty;
  assign drop   = valid_i && fifo_bus.full && !pop;

  assign fifo_bus.pop   = pop;
  assign fifo_bus.push  = valid_i && (!fifo_bus.full || pop);
  assign fifo_bus.wdata = data24_i;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    if (pop) begin
      hold_d  = fifo_bus.rdata;
      state_d = HEADER_EN ? HDR : B2;
      byte_d  = HEADER_EN ? HEADER : fifo_bus.rdata[23:16];
      valid_d = 1'b1;
    end else if (accept) begin
      case (state_q)
        HDR: begin state_d = B2; byte_d = hold_q[23:16]; end
        B2:  begin state_d = B1; byte_d = hold_q[15:8];  end
        B1:  begin state_d = B0; byte_d = hold_q[7:0];   end
        B0:  begin state_d = IDLE; byte_d = '0; valid_d = 1'b0; end
        default: begin state_d = IDLE; byte_d = '0; valid_d = 1'b0; end
      endcase
    end
    // A drop on the clearing edge must still be reported.
    ovf_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign fill_o       = fifo_bus.count;
  assign overflow_o   = ovf_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_i2s_sample_byte_packer.sv
// Directed bench for i2s_sample_byte_packer: headerless and header instances,
// latency, backpressure, overflow, full push-with-pop and mid-byte reset.
module tb_i2s_sample_byte_packer;
  import i2s_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic [23:0]   data24  = '0;
  logic          valid0  = 1'b0;
  logic          valid1  = 1'b0;
  logic          ready   = 1'b0;
  logic          clr_ovf = 1'b0;

  i2s_byte_if bs0 ();
  i2s_byte_if bs1 ();
  assign bs0.ready = ready;
  assign bs1.ready = ready;

  logic [FW-1:0] fill0, fill1;
  logic          ovf0, ovf1;
  pack_state_e   dbg0, dbg1;

  i2s_sample_byte_packer #(.DEPTH(DEPTH), .HEADER_EN(1'b0), .HEADER(8'hA5)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data24_i(data24), .valid_i(valid0),
    .byte_o(bs0.data), .byte_valid_o(bs0.valid), .byte_ready_i(bs0.ready),
    .fill_o(fill0), .overflow_o(ovf0), .clr_ovf_i(clr_ovf), .dbg_state_o(dbg0)
  );

  i2s_sample_byte_packer #(.DEPTH(DEPTH), .HEADER_EN(1'b1), .HEADER(8'hA5)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data24_i(data24), .valid_i(valid1),
    .byte_o(bs1.data), .byte_valid_o(bs1.valid), .byte_ready_i(bs1.ready),
    .fill_o(fill1), .overflow_o(ovf1), .clr_ovf_i(clr_ovf), .dbg_state_o(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         stall_q = 1'b0;
  logic [7:0] stall_byte = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted byte of dut0 is matched against the expected queue, and a
  // stalled byte must not change before it is taken.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en && rst_n) begin
      if (stall_q) begin
        check("stall_valid", 32'(bs0.valid), 32'd1);
        check("stall_byte", 32'(bs0.data), 32'(stall_byte));
      end
      if (bs0.valid && ready) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("stream_byte", 32'(bs0.data), 32'(e));
        end
      end
      stall_q    = bs0.valid && !ready;
      stall_byte = bs0.data;
    end else begin
      stall_q = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [23:0] s);
    exp_q.push_back(s[23:16]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
  endtask

  task automatic push0(input logic [23:0] s);
    data24 = s;
    valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 300;
    ready = 1'b1;
    while ((exp_q.size() != 0 || bs0.valid) && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(bs0.valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] s;
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(bs0.valid), 32'd0);
    check("rst_byte", 32'(bs0.data), 32'd0);
    check("rst_fill", 32'(fill0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_state", 32'(dbg0), 32'(IDLE));
    check("rst_valid1", 32'(bs1.valid), 32'd0);
    check("rst_state1", 32'(dbg1), 32'(IDLE));

    // Single sample, no header: fill 0->1->0, bytes 12 34 56 back to back
    mon_en = 1'b1;
    ready  = 1'b1;
    enqueue(24'h123456);
    push0(24'h123456);
    check("lat_fill1", 32'(fill0), 32'd1);
    check("lat_novalid", 32'(bs0.valid), 32'd0);
    tick();
    check("lat_valid", 32'(bs0.valid), 32'd1);
    check("lat_b2", 32'(bs0.data), 32'h12);
    check("lat_fill0", 32'(fill0), 32'd0);
    tick();
    check("lat_b1", 32'(bs0.data), 32'h34);
    tick();
    check("lat_b0", 32'(bs0.data), 32'h56);
    tick();
    check("lat_end", 32'(bs0.valid), 32'd0);

    // Header instance: A5 80 00 01 on consecutive cycles
    data24 = 24'h800001;
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    check("hdr_fill1", 32'(fill1), 32'd1);
    tick();
    check("hdr_v", 32'(bs1.valid), 32'd1);
    check("hdr_a5", 32'(bs1.data), 32'hA5);
    tick();
    check("hdr_80", 32'(bs1.data), 32'h80);
    tick();
    check("hdr_00", 32'(bs1.data), 32'h00);
    tick();
    check("hdr_01", 32'(bs1.data), 32'h01);
    tick();
    check("hdr_end", 32'(bs1.valid), 32'd0);

    // Backpressure with random ready
    enqueue(24'hC0FFEE); enqueue(24'h7F0080); enqueue(24'h000000); enqueue(24'hFFFFFF);
    ready = 1'($urandom_range(0, 1)); push0(24'hC0FFEE);
    ready = 1'($urandom_range(0, 1)); push0(24'h7F0080);
    ready = 1'($urandom_range(0, 1)); push0(24'h000000);
    ready = 1'($urandom_range(0, 1)); push0(24'hFFFFFF);
    repeat (40) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("bp");
    check("bp_ovf", 32'(ovf0), 32'd0);

    // Overflow: 10 samples with ready low, the 10th is dropped
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};
      if (i < 9) enqueue(s);
      push0(s);
    end
    check("ovf_fill", 32'(fill0), 32'd8);
    check("ovf_set", 32'(ovf0), 32'd1);
    check("ovf_hold", 32'(bs0.data), 32'h10);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(ovf0), 32'd0);
    check("ovf_fill_kept", 32'(fill0), 32'd8);

    // Full FIFO: push on the same edge as the last-byte accept
    ready = 1'b1;
    tick(); tick();
    check("full_at_b0", 32'(dbg0), 32'(B0));
    enqueue(24'h556677);
    push0(24'h556677);
    check("full_fill", 32'(fill0), 32'd8);
    check("full_ovf", 32'(ovf0), 32'd0);
    check("full_next", 32'(bs0.data), 32'h11);
    drain("ovf");

    // Reset in the middle of a sample
    mon_en = 1'b0;
    ready  = 1'b0;
    push0(24'hABCDEF);
    tick();
    check("mid_b2", 32'(bs0.data), 32'hAB);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("mid_b1", 32'(bs0.data), 32'hCD);
    check("mid_state", 32'(dbg0), 32'(B1));
    push0(24'h111111);
    check("mid_fill", 32'(fill0), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(bs0.valid), 32'd0);
    check("mid_rst_fill", 32'(fill0), 32'd0);
    check("mid_rst_byte", 32'(bs0.data), 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    ready  = 1'b1;
    enqueue(24'h654321);
    push0(24'h654321);
    tick();
    check("post_rst_msb", 32'(bs0.data), 32'h65);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
